// File: rtl/ides4_align_pkg.sv
// Shared constants and types for the GW2A IDES4 primitive model and its
// training-word aligner.
package ides4_align_pkg;

  // Deserialised word width and the bit history needed to cover every offset.
  localparam int unsigned Ides4Width = 4;
  localparam int unsigned HistWidth  = 8;

  // Default training word and lock threshold.
  localparam logic [Ides4Width-1:0] TrainDefault     = 4'b1100;
  localparam int unsigned           LockCountDefault = 4;

  // Number of offsets that can be tried before giving up.
  localparam logic [1:0] MaxTries = 2'd3;

  typedef enum logic [2:0] {
    StManual,
    StCheck,
    StSettle,
    StLocked,
    StFail
  } align_state_e;

  // Bit offset advance; wraps 3 -> 0.
  function automatic logic [1:0] slip_next(input logic [1:0] s);
    return s + 2'd1;
  endfunction

endpackage

// File: rtl/ides4_window.sv
// Bit history register and offset window mux. The window is taken from the
// history as it will look after this cycle's shift, so the parent can load it
// on the same edge that captures the last pair of a word.
module ides4_window
  import ides4_align_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  d0_i,
  input  logic                  d1_i,
  input  logic [1:0]            slip_i,
  output logic [Ides4Width-1:0] win_o
);

  logic [HistWidth-1:0] hist_q, hist_d;

  // Newest pair enters at the top; D1 is the later bit of the pair.
  always_comb begin
    hist_d = {d1_i, d0_i, hist_q[HistWidth-1:2]};
  end

  // History register, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Window select: Q[i] = hist_d[4 + i - s], i.e. s bits further into the past.
  always_comb begin
    win_o = hist_d[7:4];
    unique case (slip_i)
      2'd0: win_o = hist_d[7:4];
      2'd1: win_o = hist_d[6:3];
      2'd2: win_o = hist_d[5:2];
      2'd3: win_o = hist_d[4:1];
      default: win_o = hist_d[7:4];
    endcase
  end

endmodule

// File: rtl/ides4_align.sv
// 1:4 deserialiser behind an IDDR with manual bitslip and automatic
// training-word alignment.
module ides4_align
  import ides4_align_pkg::*;
#(
  parameter logic [Ides4Width-1:0] TRAIN      = TrainDefault,
  parameter int unsigned           LOCK_COUNT = LockCountDefault
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  D0,
  input  logic                  D1,
  input  logic                  CALIB,
  input  logic                  ALIGN,
  output logic [Ides4Width-1:0] Q,
  output logic                  VALID,
  output logic [1:0]            SLIP,
  output logic                  LOCKED,
  output logic                  FAIL
);

  localparam logic [3:0] LockCnt = LOCK_COUNT[3:0];

  logic                  phase_q;
  logic                  valid_q;
  logic [Ides4Width-1:0] q_q, q_d;
  logic [Ides4Width-1:0] win;
  logic [1:0]            s_q, s_d;
  logic                  calib_q;
  logic                  pend_q, pend_d;
  logic                  calib_rise;
  logic                  man_slip;
  logic                  fsm_slip;
  logic [3:0]            match_q, match_d;
  logic [3:0]            match_inc;
  logic [1:0]            tries_q, tries_d;
  align_state_e          state_q, state_d;

  ides4_window u_window (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .d0_i   (D0),
    .d1_i   (D1),
    .slip_i (s_q),
    .win_o  (win)
  );

  // A word completes on every edge where phase_q is set.
  always_comb begin
    q_d = q_q;
    if (phase_q) begin
      q_d = win;
    end
  end

  // Word framing: phase toggle, word register and one-cycle VALID strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q <= 1'b0;
      valid_q <= 1'b0;
      q_q     <= '0;
    end else begin
      phase_q <= ~phase_q;
      valid_q <= phase_q;
      q_q     <= q_d;
    end
  end

  // Manual slip: one accepted CALIB edge per emitted word. The pending flag
  // clears only on a load that already used the new offset.
  always_comb begin
    calib_rise = CALIB & ~calib_q;
    man_slip   = ~ALIGN & calib_rise & ~pend_q;
    pend_d     = pend_q;
    if (phase_q && pend_q) begin
      pend_d = 1'b0;
    end else if (man_slip) begin
      pend_d = 1'b1;
    end
    s_d = s_q;
    if (man_slip || fsm_slip) begin
      s_d = slip_next(s_q);
    end
  end

  // Offset, CALIB edge detector and pending-slip registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_q     <= 2'd0;
      calib_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      s_q     <= s_d;
      calib_q <= CALIB;
      pend_q  <= pend_d;
    end
  end

  // Alignment FSM next state; compares act on the word currently shown on Q.
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    tries_d   = tries_q;
    fsm_slip  = 1'b0;
    match_inc = match_q + 4'd1;
    if (!ALIGN) begin
      state_d = StManual;
    end else begin
      case (state_q)
        StManual: begin
          state_d = StCheck;
          match_d = 4'd0;
          tries_d = 2'd0;
        end
        StCheck: begin
          if (valid_q) begin
            if (q_q == TRAIN) begin
              match_d = match_inc;
              if (match_inc == LockCnt) begin
                state_d = StLocked;
              end
            end else begin
              match_d = 4'd0;
              if (tries_q == MaxTries) begin
                state_d = StFail;
              end else begin
                fsm_slip = 1'b1;
                tries_d  = tries_q + 2'd1;
                state_d  = StSettle;
              end
            end
          end
        end
        StSettle: begin
          // The first word after a slip is dropped unexamined.
          if (valid_q) begin
            state_d = StCheck;
          end
        end
        StLocked: state_d = StLocked;
        StFail:   state_d = StFail;
        default:  state_d = StManual;
      endcase
    end
  end

  // Alignment FSM state and counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StManual;
      match_q <= 4'd0;
      tries_q <= 2'd0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      tries_q <= tries_d;
    end
  end

  assign Q      = q_q;
  assign VALID  = valid_q;
  assign SLIP   = s_q;
  assign LOCKED = (state_q == StLocked);
  assign FAIL   = (state_q == StFail);

endmodule

// File: tb/tb_ides4_align.sv
// Self-checking bench for ides4_align: table of windowed words, CALIB slip
// sequences and training-alignment scenarios.
module tb_ides4_align;

  logic       clk = 1'b0;
  logic       rst, d0, d1, calib, align;
  logic [3:0] q;
  logic       valid, locked, fail;
  logic [1:0] slip;

  ides4_align #(
    .TRAIN      (4'b1100),
    .LOCK_COUNT (4)
  ) dut (
    .CLK    (clk),
    .RESET  (rst),
    .D0     (d0),
    .D1     (d1),
    .CALIB  (calib),
    .ALIGN  (align),
    .Q      (q),
    .VALID  (valid),
    .SLIP   (slip),
    .LOCKED (locked),
    .FAIL   (fail)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_bad = 0;
  int         p;
  logic       sent[$];
  logic [3:0] exp_q[$];
  logic [1:0] s_exp;
  bit         pend;
  logic       calib_prev;
  bit         sb_on;

  typedef struct {
    logic [1:0] s;
    logic [3:0] w0;
    logic [3:0] w1;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic sbit(input int mode, input int j);
    case (mode)
      0: return (j % 4) >= 2;
      1: return ((j + 3) % 4) >= 2;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive a pair, update the model, sample after the edge.
  task automatic cycle(input logic b0, input logic b1, input logic cal);
    logic       load, rise;
    int         idx;
    logic [3:0] w;
    d0 = b0;
    d1 = b1;
    calib = cal;
    sent.push_back(b0);
    sent.push_back(b1);
    load = p[0];
    if (load && sb_on) begin
      for (int i = 0; i < 4; i++) begin
        idx = 2 * p - 2 + i - int'(s_exp);
        w[i] = (idx >= 0) ? sent[idx] : 1'b0;
      end
      exp_q.push_back(w);
    end
    rise = cal & ~calib_prev;
    if (load && pend) begin
      pend = 1'b0;
    end else if (!align && rise && !pend) begin
      pend  = 1'b1;
      s_exp = s_exp + 2'd1;
    end
    calib_prev = cal;
    @(posedge clk);
    #1;
    check("valid_timing", {31'd0, valid}, {31'd0, load});
    if (valid && exp_q.size() > 0) begin
      check("sb_word", {28'd0, q}, {28'd0, exp_q.pop_front()});
    end
    p++;
  endtask

  task automatic do_reset(input logic al);
    rst   = 1'b1;
    d0    = 1'b0;
    d1    = 1'b0;
    calib = 1'b0;
    align = al;
    @(posedge clk);
    #1;
    check("rst_q",      {28'd0, q},      32'd0);
    check("rst_valid",  {31'd0, valid},  32'd0);
    check("rst_slip",   {30'd0, slip},   32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_fail",   {31'd0, fail},   32'd0);
    rst = 1'b0;
    p = 0;
    sent.delete();
    exp_q.delete();
    s_exp = 2'd0;
    pend = 1'b0;
    calib_prev = 1'b0;
  endtask

  task automatic stream_until(input int mode, input int budget, output int words);
    int j;
    words = 0;
    for (int c = 0; c < budget; c++) begin
      j = sent.size();
      cycle(sbit(mode, j), sbit(mode, j + 1), 1'b0);
      if (valid) words++;
      if (locked || fail) break;
    end
  endtask

  task automatic run_cycles(input int mode, input int n, output int words);
    int j;
    words = 0;
    for (int c = 0; c < n; c++) begin
      j = sent.size();
      cycle(sbit(mode, j), sbit(mode, j + 1), 1'b0);
      if (valid) words++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         words;
    logic [1:0] exp_a[5];
    logic [1:0] exp_b[5];

    tbl[0] = '{s: 2'd0, w0: 4'b0000, w1: 4'b1100, exp: 4'b1100};
    tbl[1] = '{s: 2'd1, w0: 4'b1010, w1: 4'b0101, exp: 4'b1011};
    tbl[2] = '{s: 2'd2, w0: 4'b1100, w1: 4'b0110, exp: 4'b1011};
    tbl[3] = '{s: 2'd3, w0: 4'b1110, w1: 4'b0001, exp: 4'b1111};
    tbl[4] = '{s: 2'd0, w0: 4'b1111, w1: 4'b0110, exp: 4'b0110};
    tbl[5] = '{s: 2'd1, w0: 4'b0111, w1: 4'b1001, exp: 4'b0010};
    tbl[6] = '{s: 2'd3, w0: 4'b0001, w1: 4'b1110, exp: 4'b0000};
    exp_a = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_b = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

    rst = 1'b1; d0 = 1'b0; d1 = 1'b0; calib = 1'b0; align = 1'b0;
    sb_on = 1'b1;
    p = 0; s_exp = 2'd0; pend = 1'b0; calib_prev = 1'b0;
    @(posedge clk);
    #1;

    // Reset release with the aligned training stream: first word is 1100.
    do_reset(1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("first_q",    {28'd0, q},    32'h0000000c);
    check("first_slip", {30'd0, slip}, 32'd0);
    check("sb_drain0",  exp_q.size(),  32'd0);

    // Table: offset set by CALIB pulses, then two words; check the second.
    foreach (tbl[v]) begin
      do_reset(1'b0);
      for (int k = 0; k < int'(tbl[v].s); k++) begin
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
      end
      check("tbl_slip", {30'd0, slip}, {30'd0, tbl[v].s});
      cycle(tbl[v].w0[0], tbl[v].w0[1], 1'b0);
      cycle(tbl[v].w0[2], tbl[v].w0[3], 1'b0);
      cycle(tbl[v].w1[0], tbl[v].w1[1], 1'b0);
      cycle(tbl[v].w1[2], tbl[v].w1[3], 1'b0);
      check("tbl_q", {28'd0, q}, {28'd0, tbl[v].exp});
      check("tbl_drain", exp_q.size(), 32'd0);
    end

    // CALIB edges each separated by a word: all count, offset wraps 3 -> 0.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      check("cal_a_slip", {30'd0, slip}, {30'd0, exp_a[i]});
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    check("cal_a_drain", exp_q.size(), 32'd0);

    // CALIB edges on load edges: every second one arrives while pending.
    do_reset(1'b0);
    cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      check("cal_b_slip", {30'd0, slip}, {30'd0, exp_b[i]});
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 4; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    check("cal_b_drain", exp_q.size(), 32'd0);

    // Auto-alignment runs: the scoreboard model does not track FSM slips.
    sb_on = 1'b0;

    // Aligned stream locks after four words, no slips; then holds on bad data.
    do_reset(1'b1);
    stream_until(0, 40, words);
    check("a0_words",  words,             32'd4);
    check("a0_locked", {31'd0, locked},   32'd1);
    check("a0_fail",   {31'd0, fail},     32'd0);
    check("a0_slip",   {30'd0, slip},     32'd0);
    cycle(1'b0, 1'b0, 1'b1);
    run_cycles(2, 6, words);
    check("a0_hold_locked", {31'd0, locked}, 32'd1);
    check("a0_hold_slip",   {30'd0, slip},   32'd0);

    // Stream delayed by one bit: three slips, lock at offset 3.
    do_reset(1'b1);
    stream_until(1, 60, words);
    check("a1_words",  words,           32'd10);
    check("a1_locked", {31'd0, locked}, 32'd1);
    check("a1_fail",   {31'd0, fail},   32'd0);
    check("a1_slip",   {30'd0, slip},   32'd3);

    // Constant zero: four mismatches then FAIL, held until ALIGN drops.
    do_reset(1'b1);
    stream_until(2, 60, words);
    check("a2_words",  words,           32'd7);
    check("a2_fail",   {31'd0, fail},   32'd1);
    check("a2_locked", {31'd0, locked}, 32'd0);
    check("a2_slip",   {30'd0, slip},   32'd3);
    run_cycles(0, 6, words);
    check("a2_hold_fail", {31'd0, fail}, 32'd1);
    align = 1'b0;
    run_cycles(2, 1, words);
    check("a2_drop_fail", {31'd0, fail}, 32'd0);
    check("a2_drop_slip", {30'd0, slip}, 32'd3);

    // Reset mid-check with two matches counted: the count must restart.
    do_reset(1'b1);
    run_cycles(0, 5, words);
    check("r_words",  words,           32'd2);
    check("r_locked", {31'd0, locked}, 32'd0);
    do_reset(1'b1);
    stream_until(0, 40, words);
    check("r_relock_words", words,           32'd4);
    check("r_relock",       {31'd0, locked}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
